// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with flush, bubble and a saturating stall counter.
// Define PIPE_SKID_EN to add one skid entry, which removes the combinational out_ready -> in_ready path.
module pipe_stage_reg #(
  parameter int DATA_W = 128,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  input  logic              bubble,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              accept, emit, main_free;

  assign emit      = valid_q & out_ready;
  assign main_free = !valid_q | emit;
  assign accept    = in_valid & in_ready;

`ifdef PIPE_SKID_EN
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;

  assign in_ready = !skid_valid_q & !bubble;

  always_comb begin
    // NOTE: every _d is given its hold value first, so no branch can leave it unassigned and infer a latch.
    valid_d      = valid_q;
    data_d       = data_q;
    ctrl_d       = ctrl_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_ctrl_d  = skid_ctrl_q;
    if (flush) begin
      valid_d      = 1'b0;
      data_d       = '0;
      ctrl_d       = '0;
      skid_valid_d = 1'b0;
      skid_data_d  = '0;
      skid_ctrl_d  = '0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        // Skid drains into main; a same-cycle accept refills the skid.
        valid_d      = 1'b1;
        data_d       = skid_data_q;
        ctrl_d       = skid_ctrl_q;
        skid_valid_d = accept;
        skid_data_d  = accept ? in_data : skid_data_q;
        skid_ctrl_d  = accept ? in_ctrl : '0;
      end else if (accept) begin
        valid_d = 1'b1;
        data_d  = in_data;
        ctrl_d  = in_ctrl;
      end else begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
      skid_ctrl_d  = in_ctrl;
    end
  end
`else
  assign in_ready = main_free & !bubble;

  always_comb begin
    // NOTE: every _d is given its hold value first, so no branch can leave it unassigned and infer a latch.
    valid_d = valid_q;
    data_d  = data_q;
    ctrl_d  = ctrl_q;
    if (flush) begin
      valid_d = 1'b0;
      data_d  = '0;
      ctrl_d  = '0;
    end else if (main_free) begin
      if (accept) begin
        valid_d = 1'b1;
        data_d  = in_data;
        ctrl_d  = in_ctrl;
      end else begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end
    end
  end
`endif

  // Stall counter ignores flush; only reset clears it.
  always_comb begin
    cnt_d = cnt_q;
    if (valid_q && !out_ready && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      valid_q      <= 1'b0;
      data_q       <= '0;
      ctrl_q       <= '0;
      cnt_q        <= '0;
`ifdef PIPE_SKID_EN
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_ctrl_q  <= '0;
`endif
    end else begin
      valid_q      <= valid_d;
      data_q       <= data_d;
      ctrl_q       <= ctrl_d;
      cnt_q        <= cnt_d;
`ifdef PIPE_SKID_EN
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_ctrl_q  <= skid_ctrl_d;
`endif
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_ctrl  = ctrl_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg: directed scenarios plus randomized traffic against a queue model.
`timescale 1ns/1ps
module tb_pipe_stage_reg;

  localparam int DATA_W = 32;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid, in_ready, flush, bubble, out_valid, out_ready;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [CNT_W-1:0]  stall_cnt;

  int errors = 0;
  int checks = 0;

  pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .flush(flush), .bubble(bubble),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: the stage is an in-order queue of beats (capacity 1, or 2 with the skid).
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [CTRL_W-1:0] ctrl;
  } beat_t;

  beat_t             mq[$];
  logic [DATA_W-1:0] m_last = '0;
  int                m_cnt  = 0;

  function automatic bit m_in_ready();
    if (bubble) return 1'b0;
    if (SKID) return mq.size() < 2;
    return (mq.size() == 0) || out_ready;
  endfunction

  function automatic bit m_out_valid();
    return mq.size() != 0;
  endfunction

  function automatic logic [DATA_W-1:0] m_out_data();
    return (mq.size() != 0) ? mq[0].data : m_last;
  endfunction

  function automatic logic [CTRL_W-1:0] m_out_ctrl();
    return (mq.size() != 0) ? mq[0].ctrl : '0;
  endfunction

  // Advance DUT and model across one rising edge; returns on the following falling edge.
  task automatic tick();
    bit    acc, emt, stl;
    beat_t b;
    acc = in_valid && m_in_ready();
    emt = (mq.size() != 0) && out_ready;
    stl = (mq.size() != 0) && !out_ready;
    b.data = in_data;
    b.ctrl = in_ctrl;
    @(posedge clk);
    if (!rst) begin
      mq.delete();
      m_last = '0;
      m_cnt  = 0;
    end else begin
      if (stl && m_cnt < (2**CNT_W) - 1) m_cnt++;
      if (flush) begin
        mq.delete();
        m_last = '0;
      end else begin
        if (emt) begin
          m_last = mq[0].data;
          void'(mq.pop_front());
        end
        if (acc) mq.push_back(b);
      end
    end
    @(negedge clk);
  endtask

  task automatic set_idle();
    in_valid  = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
    flush     = 1'b0;
    bubble    = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_idle();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    checks++; if (out_ctrl !== '0) begin errors++; $display("FAIL reset_out_ctrl: got %h want 0", out_ctrl); end
    checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    bubble = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_bubble_in_ready: got %b want 0", in_ready); end
    bubble = 1'b0;
    tick();
  endtask

  task automatic test_streaming();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = DATA_W'(i); in_ctrl = CTRL_W'(16 + i); out_ready = 1'b1;
      #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready beat %0d: got %b want 1", i, in_ready); end
      if (i > 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== DATA_W'(i - 1) || out_ctrl !== CTRL_W'(15 + i)) begin
          errors++; $display("FAIL stream_out beat %0d: got v=%b d=%0d c=%h want v=1 d=%0d c=%h", i, out_valid, out_data, out_ctrl, i - 1, 15 + i);
        end
      end
      tick();
    end
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== DATA_W'(4)) begin errors++; $display("FAIL stream_last: got v=%b d=%0d want v=1 d=4", out_valid, out_data); end
    checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL stream_stall_cnt: got %0d want 0", stall_cnt); end
    tick();
    #1;
    checks++; if (out_valid !== 1'b0 || out_ctrl !== '0) begin errors++; $display("FAIL stream_drained: got v=%b c=%h want v=0 c=0", out_valid, out_ctrl); end
  endtask

  task automatic test_backpressure();
    logic [DATA_W-1:0] got[$];
    int sent = 1;
    int cyc  = 0;
    bit want_rdy;
    do_reset();
    while (got.size() < 4 && cyc < 30) begin
      in_valid  = (sent <= 4);
      in_data   = DATA_W'(sent);
      in_ctrl   = 16'h00A0;
      out_ready = !(cyc >= 1 && cyc <= 3);
      #1;
      if (cyc >= 1 && cyc <= 3) begin
        want_rdy = SKID && (cyc == 1);
        checks++; if (out_valid !== 1'b1 || out_data !== DATA_W'(1)) begin errors++; $display("FAIL bp_hold cycle %0d: got v=%b d=%0d want v=1 d=1", cyc, out_valid, out_data); end
        checks++; if (in_ready !== want_rdy) begin errors++; $display("FAIL bp_in_ready cycle %0d: got %b want %b", cyc, in_ready, want_rdy); end
      end
      if (cyc == 4) begin
        checks++; if (stall_cnt !== CNT_W'(3)) begin errors++; $display("FAIL bp_stall_cnt: got %0d want 3", stall_cnt); end
      end
      if (out_valid && out_ready) got.push_back(out_data);
      if (in_valid && m_in_ready()) sent++;
      tick();
      cyc++;
    end
    checks++; if (got.size() != 4) begin errors++; $display("FAIL bp_count: got %0d beats want 4", got.size()); end
    for (int k = 0; k < got.size() && k < 4; k++) begin
      checks++; if (got[k] !== DATA_W'(k + 1)) begin errors++; $display("FAIL bp_order beat %0d: got %0d want %0d", k, got[k], k + 1); end
    end
    set_idle();
    #1;
    checks++; if (stall_cnt !== CNT_W'(3)) begin errors++; $display("FAIL bp_stall_final: got %0d want 3", stall_cnt); end
  endtask

  task automatic test_flush();
    do_reset();
    in_valid = 1'b1; in_data = DATA_W'(7); in_ctrl = 16'hFFFF; out_ready = 1'b0;
    tick();
    in_data = DATA_W'(8);
    #1;
    checks++; if (out_valid !== 1'b1 || out_ctrl !== 16'hFFFF) begin errors++; $display("FAIL flush_pre: got v=%b c=%h want v=1 c=ffff", out_valid, out_ctrl); end
    tick();
    in_data = DATA_W'(9); flush = 1'b1; out_ready = 1'b1;
    tick();
    set_idle();
    #1;
    checks++; if (out_valid !== 1'b0 || out_ctrl !== '0 || out_data !== '0) begin errors++; $display("FAIL flush_clear: got v=%b d=%0d c=%h want all 0", out_valid, out_data, out_ctrl); end
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      checks++; if (out_valid !== 1'b0 || out_data === DATA_W'(9)) begin errors++; $display("FAIL flush_after cycle %0d: got v=%b d=%0d want v=0 d!=9", i, out_valid, out_data); end
    end
  endtask

  task automatic test_bubble();
    do_reset();
    in_valid = 1'b1; in_data = DATA_W'(5); in_ctrl = 16'h0055; out_ready = 1'b1;
    tick();
    in_data = DATA_W'(6); in_ctrl = 16'h0066; bubble = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== DATA_W'(5)) begin errors++; $display("FAIL bubble_pre: got v=%b d=%0d want v=1 d=5", out_valid, out_data); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bubble_in_ready: got %b want 0", in_ready); end
    tick();
    bubble = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || out_ctrl !== '0) begin errors++; $display("FAIL bubble_slot: got v=%b c=%h want v=0 c=0", out_valid, out_ctrl); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bubble_release_ready: got %b want 1", in_ready); end
    tick();
    in_valid = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b1 || out_data !== DATA_W'(6) || out_ctrl !== 16'h0066) begin errors++; $display("FAIL bubble_next: got v=%b d=%0d c=%h want v=1 d=6 c=0066", out_valid, out_data, out_ctrl); end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    in_valid = 1'b1; in_data = 32'hABCD; in_ctrl = 16'h0F0F; out_ready = 1'b1;
    tick();
    in_valid = 1'b0; out_ready = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 10) begin
        #1;
        checks++; if (stall_cnt !== CNT_W'(10)) begin errors++; $display("FAIL sat_mid: got %0d want 10", stall_cnt); end
      end
    end
    #1;
    checks++; if (stall_cnt !== CNT_W'(15)) begin errors++; $display("FAIL sat_cap: got %0d want 15", stall_cnt); end
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hABCD) begin errors++; $display("FAIL sat_hold: got v=%b d=%h want v=1 d=abcd", out_valid, out_data); end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0 || out_data !== '0 || out_ctrl !== '0) begin errors++; $display("FAIL sat_reset_out: got v=%b d=%h c=%h want all 0", out_valid, out_data, out_ctrl); end
    checks++; if (stall_cnt !== '0) begin errors++; $display("FAIL sat_reset_cnt: got %0d want 0", stall_cnt); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL sat_reset_ready: got %b want 1", in_ready); end
    set_idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      rst       = ($urandom_range(99) != 0);
      flush     = ($urandom_range(24) == 0);
      bubble    = ($urandom_range(5) == 0);
      out_ready = ($urandom_range(2) != 0);
      in_valid  = ($urandom_range(3) != 0);
      in_data   = DATA_W'($urandom);
      in_ctrl   = CTRL_W'($urandom);
      #1;
      checks++; if (in_ready !== m_in_ready()) begin errors++; $display("FAIL rnd_in_ready cycle %0d: got %b want %b", cyc, in_ready, m_in_ready()); end
      checks++; if (out_valid !== m_out_valid()) begin errors++; $display("FAIL rnd_out_valid cycle %0d: got %b want %b", cyc, out_valid, m_out_valid()); end
      checks++; if (out_data !== m_out_data()) begin errors++; $display("FAIL rnd_out_data cycle %0d: got %h want %h", cyc, out_data, m_out_data()); end
      checks++; if (out_ctrl !== m_out_ctrl()) begin errors++; $display("FAIL rnd_out_ctrl cycle %0d: got %h want %h", cyc, out_ctrl, m_out_ctrl()); end
      checks++; if (stall_cnt !== CNT_W'(m_cnt)) begin errors++; $display("FAIL rnd_stall_cnt cycle %0d: got %0d want %0d", cyc, stall_cnt, m_cnt); end
      checks++; if (!out_valid && out_ctrl !== '0) begin errors++; $display("FAIL rnd_ctrl_invariant cycle %0d: got c=%h with v=0 want 0", cyc, out_ctrl); end
      tick();
    end
    rst = 1'b1;
    set_idle();
  endtask

  initial begin
    rst = 1'b0;
    set_idle();
    @(negedge clk);
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_bubble();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached before the summary");
    $fatal(1);
  end

endmodule
